// File: rtl/id_decode.sv
// id_decode: RV32I ID-stage front end; decodes the opcode into immediate-format select and register indices behind a 2-entry skid buffer.
// Ports: clk/rst (sync, active-high); if_valid/if_ready/if_instr/if_pc fetch handshake;
//        flush drops both held entries; id_valid/id_ready downstream handshake;
//        id_instr (instr[31:7]), id_immsel (one-hot I,S,B,U,J), id_pc, id_rd/id_rs1/id_rs2, id_illegal.
// Optional macro ID_DECODE_PERF_EN adds perf_decoded / perf_stall counters.
module id_decode #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [24:0]     id_instr,
    output logic [4:0]      id_immsel,
    output logic [PC_W-1:0] id_pc,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic            id_illegal
`ifdef ID_DECODE_PERF_EN
    ,
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_stall
`endif
);
    typedef struct packed {
        logic [24:0]     instr;
        logic [4:0]      immsel;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } entry_t;

    entry_t     dec, main_q, main_d, skid_q, skid_d;
    logic       main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic       up, dn, ill;
    logic [4:0] sel;
    logic [6:0] op;
    logic [2:0] f3;

    assign op = if_instr[6:0];
    assign f3 = if_instr[14:12];

    // Unlisted opcodes (including any with instr[1:0] != 11) fall to default and are illegal.
    always_comb begin
        sel = 5'b00000;
        ill = 1'b0;
        case (op)
            7'b0000011: begin sel = 5'b00001; ill = f3 == 3'b011 || f3[2:1] == 2'b11; end
            7'b0010011, 7'b1110011, 7'b0001111: sel = 5'b00001;
            7'b1100111: begin sel = 5'b00001; ill = f3 != 3'b000; end
            7'b0100011: begin sel = 5'b00010; ill = f3 >= 3'b011; end
            7'b1100011: begin sel = 5'b00100; ill = f3[2:1] == 2'b01; end
            7'b0110111, 7'b0010111: sel = 5'b01000;
            7'b1101111: sel = 5'b10000;
            7'b0110011: sel = 5'b00000;
            default: ill = 1'b1;
        endcase
        dec.instr   = if_instr[31:7];
        dec.immsel  = ill ? 5'b00000 : sel;
        dec.pc      = if_pc;
        dec.illegal = ill;
    end

    // Ready depends only on registered skid occupancy, never on id_ready.
    assign if_ready = ~rst & ~skid_v_q;
    assign up       = if_valid & if_ready;
    assign dn       = main_v_q & id_ready;

    // Skid full implies if_ready=0, so no upstream load can collide with a skid->main move.
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (dn && skid_v_q) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
        end else if (!main_v_q || dn) begin
            main_v_d = up;
            if (up) main_d = dec;
        end else if (up) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign id_valid   = main_v_q;
    assign id_instr   = main_q.instr;
    assign id_immsel  = main_q.immsel;
    assign id_pc      = main_q.pc;
    assign id_illegal = main_q.illegal;
    assign id_rd      = main_q.instr[4:0];
    assign id_rs1     = main_q.instr[12:8];
    assign id_rs2     = main_q.instr[17:13];

`ifdef ID_DECODE_PERF_EN
    logic [31:0] perf_decoded_q, perf_decoded_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_decoded_d = perf_decoded_q + 32'(dn);
        perf_stall_d   = perf_stall_q + 32'(main_v_q & ~id_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_decoded_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_decoded_q <= perf_decoded_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_decoded = perf_decoded_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_id_decode.sv
// tb_id_decode: directed self-checking bench for id_decode.
module tb_id_decode;
    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, flush, id_valid, id_ready, id_illegal;
    logic [31:0] if_instr, if_pc, id_pc;
    logic [24:0] id_instr;
    logic [4:0]  id_immsel, id_rd, id_rs1, id_rs2;
`ifdef ID_DECODE_PERF_EN
    logic [31:0] perf_decoded, perf_stall;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    id_decode #(.PC_W(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_immsel(id_immsel), .id_pc(id_pc), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_illegal(id_illegal)
`ifdef ID_DECODE_PERF_EN
        , .perf_decoded(perf_decoded), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    logic [31:0] vec [9] = '{32'h00500093, 32'h00112423, 32'h00000463, 32'h123450B7,
                             32'h008000EF, 32'h002081B3, 32'h0000007F, 32'h00003003,
                             32'h00001067};
    logic [4:0]  sel [9] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                             5'b00000, 5'b00000, 5'b00000, 5'b00000};
    logic        ill [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; flush = 1'b0; id_ready = 1'b1;
        offer(1'b1, 32'h00500093, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick;
            check("rst_if_ready", if_ready, 0);
            check("rst_id_valid", id_valid, 0);
            check("rst_immsel", id_immsel, 0);
        end
        check("rst_illegal", id_illegal, 0);
        check("rst_pc", id_pc, 0);
        check("rst_instr", id_instr, 0);
        rst = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #1;
        check("post_rst_if_ready", if_ready, 1);
        tick;
        check("post_rst_empty", id_valid, 0);

        // decode sweep, back-to-back with id_ready=1 (no bubbles)
        for (int i = 0; i < 9; i++) begin
            offer(1'b1, vec[i], 32'h1000 + 32'(4 * i));
            tick;
            check($sformatf("sweep%0d_valid", i), id_valid, 1);
            check($sformatf("sweep%0d_immsel", i), id_immsel, sel[i]);
            check($sformatf("sweep%0d_illegal", i), id_illegal, ill[i]);
            check($sformatf("sweep%0d_pc", i), id_pc, 32'h1000 + 32'(4 * i));
            if (i == 0) begin
                check("addi_rd", id_rd, 1);
                check("addi_rs1", id_rs1, 0);
                check("addi_instr", id_instr, 25'h000A001);
            end
            if (i == 5) begin
                check("add_rd", id_rd, 3);
                check("add_rs1", id_rs1, 1);
                check("add_rs2", id_rs2, 2);
            end
            if (i == 7) check("ill_passthru", id_instr, 25'h0000060);
        end
        offer(1'b0, 32'h0, 32'h0);
        tick;
        check("sweep_drain", id_valid, 0);

        // backpressure: A main, B skid, C held off
        id_ready = 1'b0;
        offer(1'b1, 32'h00500093, 32'h100);
        tick;
        check("bp_a_pc", id_pc, 32'h100);
        check("bp_a_ready", if_ready, 1);
        offer(1'b1, 32'h00112423, 32'h104);
        tick;
        check("bp_b_ready", if_ready, 0);
        check("bp_b_hold", id_pc, 32'h100);
        offer(1'b1, 32'h00000463, 32'h108);
        tick;
        check("bp_c_ready", if_ready, 0);
        check("bp_c_hold_pc", id_pc, 32'h100);
        check("bp_c_hold_sel", id_immsel, 5'b00001);
        id_ready = 1'b1;
        tick;
        check("bp_out_b_pc", id_pc, 32'h104);
        check("bp_out_b_sel", id_immsel, 5'b00010);
        check("bp_out_b_ready", if_ready, 1);
        tick;
        check("bp_out_c_pc", id_pc, 32'h108);
        check("bp_out_c_sel", id_immsel, 5'b00100);
        check("bp_out_c_valid", id_valid, 1);
        offer(1'b0, 32'h0, 32'h0);
        tick;
        check("bp_drain", id_valid, 0);

        // flush with both entries full plus a pending offer
        id_ready = 1'b0;
        offer(1'b1, 32'h00500093, 32'h200);
        tick;
        offer(1'b1, 32'h00112423, 32'h204);
        tick;
        check("fl_full", if_ready, 0);
        offer(1'b1, 32'h00000463, 32'h208);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("fl_valid", id_valid, 0);
        check("fl_ready", if_ready, 1);
        offer(1'b0, 32'h0, 32'h0);
        id_ready = 1'b1;
        tick;
        check("fl_gone1", id_valid, 0);
        tick;
        check("fl_gone2", id_valid, 0);

        // flush drops an instruction accepted in the same cycle
        offer(1'b1, 32'h123450B7, 32'h300);
        tick;
        check("fl2_loaded", id_pc, 32'h300);
        offer(1'b1, 32'h008000EF, 32'h304);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("fl2_valid", id_valid, 0);
        tick;
        check("fl2_dropped", id_valid, 0);

`ifdef ID_DECODE_PERF_EN
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("perf_rst_dec", perf_decoded, 0);
        check("perf_rst_stall", perf_stall, 0);
        id_ready = 1'b0;
        offer(1'b1, 32'h00500093, 32'h400);
        tick;
        offer(1'b0, 32'h0, 32'h0);
        tick;
        tick;
        tick;
        check("perf_stall3", perf_stall, 3);
        check("perf_dec0", perf_decoded, 0);
        id_ready = 1'b1;
        offer(1'b1, 32'h00112423, 32'h404);
        tick;
        offer(1'b1, 32'h00000463, 32'h408);
        tick;
        offer(1'b1, 32'h123450B7, 32'h40C);
        tick;
        offer(1'b0, 32'h0, 32'h0);
        tick;
        check("perf_dec4", perf_decoded, 4);
        check("perf_stall_keep", perf_stall, 3);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("perf_fl_dec", perf_decoded, 4);
        check("perf_fl_stall", perf_stall, 3);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("perf_clr_dec", perf_decoded, 0);
        check("perf_clr_stall", perf_stall, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
